ahb_lite_sub_store: RTL

AHB_LITE_SUB_STORE -- requirements
Module: ahb_lite_sub_store

---
 rtl/ahb_lite_sub_store.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sub_store.sv
// AHB-Lite subordinate backed by a word store.
// Configurable wait states, range/alignment/lock checks and an ERROR response.
module ahb_lite_sub_store #(
  parameter int pAHB_ADDR_WIDTH  = 32,
  parameter int pAHB_DATA_WIDTH  = 32,
  parameter int pAHB_HRESP_WIDTH = 2,
  parameter int pDEPTH           = 64,
  parameter logic [pAHB_ADDR_WIDTH-1:0] pBASE_ADDR = 'h4000_0000,
  parameter int pWAIT_STATES     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        I_hsel,
  input  logic [pAHB_ADDR_WIDTH-1:0]  I_haddr,
  input  logic [1:0]                  I_htrans,
  input  logic [2:0]                  I_hsize,
  input  logic [2:0]                  I_hburst,
  input  logic [3:0]                  I_hprot,
  input  logic                        I_hwrite,
  input  logic [pAHB_DATA_WIDTH-1:0]  I_hwdata,
  input  logic                        I_hready,
  input  logic                        I_wr_lock,
  output logic                        O_hreadyout,
  output logic [pAHB_HRESP_WIDTH-1:0] O_hresp,
  output logic [pAHB_DATA_WIDTH-1:0]  O_hrdata
);

  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int IW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [AW-1:0] LIMIT = AW'(pDEPTH * 4);
  localparam logic [2:0] NWAIT = 3'(pWAIT_STATES);
  localparam logic [pAHB_HRESP_WIDTH-1:0] OKAY = '0;
  localparam logic [pAHB_HRESP_WIDTH-1:0] ERR  = 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        dp_q;
  logic        wr_q;
  logic [IW-1:0] idx_q;
  logic [1:0]  lane_q;
  logic [2:0]  size_q;
  logic        rdy_q;
  logic [pAHB_HRESP_WIDTH-1:0] resp_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [pDEPTH];

  logic [AW-1:0] ofs;
  logic [IW-1:0] nidx;
  logic          acc;
  logic          bad;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   merged;
  logic [31:0]   fwd_d;
  logic          unused_ok;

  assign unused_ok = ^{I_hburst, I_hprot, I_htrans[0]};

  always_comb begin
    ofs    = I_haddr - pBASE_ADDR;
    nidx   = ofs[IW+1:2];
    acc    = I_hsel && I_hready && I_htrans[1] &&
             (state_q == S_IDLE || state_q == S_ERR2);
    bad    = (ofs >= LIMIT) || (I_hsize > 3'd2) ||
             (I_hsize == 3'd1 && I_haddr[0]) ||
             (I_hsize == 3'd2 && I_haddr[1:0] != 2'd0) ||
             (I_hwrite && I_wr_lock);
    commit = (state_q == S_IDLE) && dp_q && wr_q;
    be     = 4'b1111;
    unique case (1'b1)
      size_q == 3'd0: be = 4'b0001 << lane_q;
      size_q == 3'd1: be = lane_q[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
    merged = mem_q[idx_q];
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = I_hwdata[8*b +: 8];
    // zero-wait read right behind a write to the same word
    fwd_d  = (commit && idx_q == nidx) ? merged : mem_q[nidx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dp_q    <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      rdy_q   <= 1'b1;
      resp_q  <= OKAY;
      rdata_q <= '0;
      for (int i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (commit) mem_q[idx_q] <= merged;
      rdy_q   <= 1'b1;
      resp_q  <= OKAY;
      rdata_q <= '0;
      dp_q    <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_q <= S_IDLE;
            dp_q    <= 1'b1;
            if (!wr_q) rdata_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 3'd1;
            rdy_q <= 1'b0;
          end
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          resp_q  <= ERR;
        end
        default: begin
          state_q <= S_IDLE;
          if (acc) begin
            idx_q  <= nidx;
            lane_q <= I_haddr[1:0];
            size_q <= I_hsize;
            wr_q   <= I_hwrite;
            if (bad) begin
              state_q <= S_ERR1;
              rdy_q   <= 1'b0;
              resp_q  <= ERR;
            end else if (NWAIT == 3'd0) begin
              dp_q <= 1'b1;
              if (!I_hwrite) rdata_q <= fwd_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= NWAIT;
              rdy_q   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign O_hreadyout = rdy_q;
  assign O_hresp     = resp_q;
  assign O_hrdata    = rdata_q;

endmodule
